lo_tap_sched: RTL
=================

Name: lo_tap_sched

Overview:
- Scheduler/configurator for a bank of NCH quadrature LO channels that all share one free-running 19-bit gray counter.
- Each channel picks a core index (tap) n. The block routes gray_clk[n+6:n] to that channel's LO window and gray_clk[n+7] to its gray_sine reference.
- Retunes and enable/disable changes are accepted through a valid/ready config port. They take effect only at a gray-count boundary, so LO outputs never glitch mid-period.

Parameters:
- NCH, 4, number of LO channels
- CNT_W, 19, width of the shared gray counter
- TAP_W, 4, width of the tap index field
- CH_W, 2, channel index width (clog2(NCH))

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gray_clk  in  CNT_W  shared gray counter value
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  block can accept a config request
- cfg_ch  in  CH_W  target channel
- cfg_tap  in  TAP_W  requested tap n
- cfg_en  in  1  requested channel enable
- cfg_err  out  1  one-cycle pulse: request rejected
- busy  out  1  a request is pending
- retune_done  out  1  one-cycle pulse: pending request applied
- lo_win  out  NCH*7  per-channel window; channel c occupies [7c+6:7c]
- lo_sine  out  NCH  per-channel gray_sine reference
- ch_en  out  NCH  current enable per channel

Behaviour:
- Reset values (all synchronous):
  - cur_tap[c] = 1 and cur_en[c] = 0 for every channel.
  - lo_win = 0, lo_sine = 0, ch_en = 0.
  - cfg_ready = 0, cfg_err = 0, busy = 0, retune_done = 0.
  - state = IDLE.
  - cfg_ready rises on the first cycle after reset deasserts.
- Output path:
  - Registered, 1-cycle latency.
  - If cur_en[c] = 1: lo_win[c] <= gray_clk[cur_tap+6:cur_tap] and lo_sine[c] <= gray_clk[cur_tap+7].
  - If cur_en[c] = 0: both are forced to 0.
- Legal tap range: 1 .. CNT_W-8 (1..11 at default).
- FSM states: IDLE, WAIT_BND, APPLY.
- IDLE:
  - cfg_ready = 1. A handshake is cfg_valid & cfg_ready.
  - Illegal tap: cfg_err pulses the next cycle, nothing is latched, state stays IDLE, cfg_ready stays 1.
  - Legal tap: latch {ch, tap, en} into the pending registers; busy = 1; cfg_ready = 0 the next cycle.
  - Next state is APPLY if any of these hold:
    - the target channel is currently disabled;
    - the request is identical to the current {tap, en};
    - the request enables a disabled channel.
  - Otherwise next state is WAIT_BND.
- WAIT_BND:
  - Let m = max(cur_tap[ch], pend_tap).
  - Boundary = gray_clk[m+6:0] == 0, evaluated combinationally each cycle.
  - On boundary, go to APPLY. No timeout: the counter always runs.
- APPLY (exactly 1 cycle):
  - cur_tap[ch] <= pend_tap; cur_en[ch] <= pend_en.
  - retune_done pulses the next cycle; busy clears; go to IDLE with cfg_ready = 1.
  - The new tap is visible on lo_win two cycles after the boundary cycle.
- Other channels are never disturbed by a retune.
- Only one request is outstanding at a time. Back-to-back requests are spaced by at least 1 IDLE cycle.
- cfg_valid while cfg_ready = 0 is ignored (no error). The requester must hold it.
- Reset mid-WAIT_BND or mid-APPLY: the pending request is discarded and all channel state returns to reset values.
- Disabling (pend_en = 0) also waits for the boundary of the current tap, so the channel stops on a complete period.
- cfg_ch ≥ NCH (only possible if NCH is not a power of 2) is treated like an illegal tap: cfg_err pulses.

Test Plan:
1. Reset held 3 cycles, then released → cfg_ready = 1 on the first cycle after release; all lo_win/lo_sine/ch_en = 0.
2. Enable ch0 at tap 2 while disabled → APPLY directly; retune_done 2 cycles after handshake; afterwards lo_win[6:0] tracks gray_clk[8:2] delayed 1 cycle, and lo_sine[0] = gray_clk[9] delayed 1.
3. ch0 enabled at tap 2, request tap 4 → busy stays high until gray_clk[10:0] == 0; lo_win[6:0] keeps showing gray_clk[8:2] until then, then switches to gray_clk[10:4]; retune_done pulses once.
4. Request tap 0, then tap 12 (default params) → cfg_err pulses each time; no state change; cfg_ready remains 1.
5. ch1 waiting for a boundary, reset asserted for 1 cycle → busy = 0 and ch_en = 0 after reset; later boundary cycles cause no retune_done.
6. ch0 enabled at tap 2 and ch2 enabled at tap 3; disable ch2 → ch2 zeroes only after gray_clk[9:0] == 0; ch0 output stays uninterrupted throughout.

Source files
------------

// File: rtl/lo_tap_sched.sv
// lo_tap_sched: per-channel LO tap scheduler that retunes only on gray-count boundaries
module lo_tap_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 19,
  parameter int TAP_W = 4,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] gray_clk,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic             cfg_en,
  output logic             cfg_err,
  output logic             busy,
  output logic             retune_done,
  output logic [NCH*7-1:0] lo_win,
  output logic [NCH-1:0]   lo_sine,
  output logic [NCH-1:0]   ch_en
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_BND = 2'd1, APPLY = 2'd2;
  logic [1:0]       state;
  logic [TAP_W-1:0] cur_tap [NCH];
  logic [NCH-1:0]   cur_en;
  logic [CH_W-1:0]  pend_ch;
  logic [TAP_W-1:0] pend_tap;
  logic             pend_en;
  logic [CNT_W-1:0] sh [NCH];
  logic [TAP_W-1:0] m;
  logic [4:0]       mw;
  logic             bnd, hs, req_ok, direct;
  assign ch_en = cur_en;
  always_comb begin
    for (int c = 0; c < NCH; c++) sh[c] = gray_clk >> cur_tap[c];
    m = cur_tap[pend_ch] > pend_tap ? cur_tap[pend_ch] : pend_tap;
    mw = 5'(m) + 5'd7;
    bnd = (gray_clk & ~({CNT_W{1'b1}} << mw)) == '0;
    hs = cfg_valid && cfg_ready;
    req_ok = cfg_tap != '0 && cfg_tap <= TAP_W'(CNT_W - 8) && (CH_W+1)'(cfg_ch) < (CH_W+1)'(NCH);
    direct = !cur_en[cfg_ch] || (cfg_en && cfg_tap == cur_tap[cfg_ch]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cfg_ready   <= 1'b0;
      cfg_err     <= 1'b0;
      busy        <= 1'b0;
      retune_done <= 1'b0;
      cur_en      <= '0;
      pend_ch     <= '0;
      pend_tap    <= '0;
      pend_en     <= 1'b0;
      lo_win      <= '0;
      lo_sine     <= '0;
      for (int c = 0; c < NCH; c++) cur_tap[c] <= TAP_W'(1);
    end else begin
      cfg_err     <= hs && !req_ok;
      retune_done <= state == APPLY;
      for (int c = 0; c < NCH; c++) begin
        lo_win[7*c +: 7] <= cur_en[c] ? sh[c][6:0] : 7'd0;
        lo_sine[c]       <= cur_en[c] && sh[c][7];
      end
      if (state == IDLE) begin
        cfg_ready <= !(hs && req_ok);
        if (hs && req_ok) begin
          pend_ch  <= cfg_ch;
          pend_tap <= cfg_tap;
          pend_en  <= cfg_en;
          busy     <= 1'b1;
          state    <= direct ? APPLY : WAIT_BND;
        end
      end else if (state == WAIT_BND) begin
        state <= bnd ? APPLY : WAIT_BND;
      end else if (state == APPLY) begin
        cur_tap[pend_ch] <= pend_tap;
        cur_en[pend_ch]  <= pend_en;
        busy             <= 1'b0;
        cfg_ready        <= 1'b1;
        state            <= IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
